// File: rtl/pipe_adder_pkg.sv
// Shared constants, FSM encoding and tag sizing for the pipelined-adder arbiter.
package pipe_adder_pkg;

   localparam int ADD_LAT   = 4;
   localparam int ADD_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   // A tag is {valid, requester id}.
   function automatic int tag_width(input int nreq);
      return 1 + $clog2(nreq);
   endfunction

endpackage

// File: rtl/pipe_adder_arbiter_rr_arbiter.sv
// Requester arbiter: round-robin from i_ptr when ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with index 0 highest (no pointer port).
module rr_arbiter
   import pipe_adder_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic [IDW-1:0]  i_ptr,
`endif
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_gnt_idx,
   output logic            o_gnt_any
);

   logic [IDW-1:0] w_j;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_gnt_any = 1'b0;
      w_j       = '0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         w_j = IDW'((int'(i_ptr) + k) % NREQ);
`else
         w_j = IDW'(k);
`endif
         if (!o_gnt_any && i_req[w_j]) begin
            o_gnt_any  = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_gnt_idx  = w_j;
         end
      end
   end

endmodule

// File: rtl/pipe_adder_arbiter.sv
// Shares one LAT-stage pipelined adder among NREQ requesters and routes each result
// back via a tag pipeline. Arbitration mode selected by ARB_ROUND_ROBIN_EN.
//
// state    | meaning
// ST_RUN   | grants allowed, results retire
// ST_DRAIN | no grants, waiting for in-flight results to retire
// ST_IDLE  | no grants, pipeline empty
module pipe_adder_arbiter
   import pipe_adder_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = ADD_WIDTH,
   parameter int LAT   = ADD_LAT
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_x,
   input  logic [NREQ*WIDTH-1:0] req_y,
   input  logic [NREQ-1:0]       req_cin,
   output logic [NREQ-1:0]       req_ready,
   output logic [WIDTH-1:0]      add_x,
   output logic [WIDTH-1:0]      add_y,
   output logic                  add_cin,
   input  logic [WIDTH-1:0]      add_sum,
   input  logic                  add_cout,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_cout,
   input  logic                  drain,
   output logic                  idle,
   output logic [2:0]            inflight
);

   localparam int IDW  = $clog2(NREQ);
   localparam int TAGW = tag_width(NREQ);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TAGW-1:0] r_tag [LAT];
   logic [2:0]      r_inflight;
   logic [2:0]      w_inflight_nxt;
   logic            w_grant_en;
   logic [NREQ-1:0] w_req;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_gnt_idx;
   logic            w_gnt_any;

   // Reset also blocks grants so nothing enters the pipeline while it is being cleared.
   assign w_grant_en = (r_state == ST_RUN) && !drain && !Rst;
   assign w_req      = req_valid & {NREQ{w_grant_en}};

`ifdef ARB_ROUND_ROBIN_EN
   logic [IDW-1:0] r_rr_ptr;

   always_ff @(posedge Clk) begin
      if (Rst)
         r_rr_ptr <= '0;
      else if (w_gnt_any)
         r_rr_ptr <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
   end
`endif

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .i_req     (w_req),
`ifdef ARB_ROUND_ROBIN_EN
      .i_ptr     (r_rr_ptr),
`endif
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_any (w_gnt_any)
   );

   assign req_ready = w_gnt;

   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         add_x   = add_x | (req_x[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
         add_y   = add_y | (req_y[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
         add_cin = add_cin | (req_cin[i] & w_gnt[i]);
      end
   end

   // Popcount of the tag valids as they will be after this edge.
   always_comb begin
      w_inflight_nxt = 3'(w_gnt_any);
      for (int k = 0; k < LAT - 1; k++)
         w_inflight_nxt = w_inflight_nxt + 3'(r_tag[k][TAGW-1]);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int k = 0; k < LAT; k++)
            r_tag[k] <= '0;
         r_inflight <= '0;
      end else begin
         r_tag[0] <= {w_gnt_any, w_gnt_idx};
         for (int k = 1; k < LAT; k++)
            r_tag[k] <= r_tag[k-1];
         r_inflight <= w_inflight_nxt;
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++)
         rsp_valid[i] = r_tag[LAT-1][TAGW-1] && (r_tag[LAT-1][IDW-1:0] == IDW'(i));
   end

   assign rsp_sum  = add_sum;
   assign rsp_cout = add_cout;
   assign idle     = (r_state == ST_IDLE);
   assign inflight = r_inflight;

   always_ff @(posedge Clk) begin
      if (Rst)
         r_state <= ST_RUN;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (drain) w_state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (!drain)
               w_state_nxt = ST_RUN;
            else if (r_inflight == 3'd0 && !w_gnt_any)
               w_state_nxt = ST_IDLE;
         end
         ST_IDLE:  if (!drain) w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

endmodule
